// File: rtl/psum_drain.sv
// psum_drain: captures the core's partial-sum vector on i_Done, requantizes each lane
//   (arithmetic shift, optional ReLU, signed saturation) and streams the lanes one per cycle.
// Latency: i_Done at edge N drives o_Vld high after edge N when the active slot is free.
// Backpressure: lanes hold while o_Vld && !i_Rdy. A pending slot absorbs one more capture
//   (o_Stall high). A capture into two full slots is dropped and o_Overflow is set.
// Ports: CLK/RST (async, active-low); i_Done/i_Psum/i_Shift/i_Relu capture side;
//   i_Rdy/o_Vld/o_Data/o_Idx/o_Last output stream; o_Stall/o_Overflow/i_Clr_Err status.
module psum_drain #(
  parameter int PE_ARRAY  = 16,
  parameter int BITS_PSUM = 20,
  parameter int BITS_OUT  = 8
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            i_Done,
  input  logic [BITS_PSUM*PE_ARRAY-1:0]   i_Psum,
  input  logic [4:0]                      i_Shift,
  input  logic                            i_Relu,
  input  logic                            i_Clr_Err,
  input  logic                            i_Rdy,
  output logic                            o_Vld,
  output logic [BITS_OUT-1:0]             o_Data,
  output logic [$clog2(PE_ARRAY)-1:0]     o_Idx,
  output logic                            o_Last,
  output logic                            o_Stall,
  output logic                            o_Overflow
);

  localparam int IW = $clog2(PE_ARRAY);
  localparam logic [IW-1:0] LAST_IDX = IW'(PE_ARRAY - 1);
  localparam logic signed [BITS_PSUM-1:0] SAT_MAX = BITS_PSUM'((2 ** (BITS_OUT - 1)) - 1);
  localparam logic signed [BITS_PSUM-1:0] SAT_MIN = -SAT_MAX - BITS_PSUM'(1);

  // Active slot (currently draining) and pending slot (waiting behind it).
  logic [BITS_PSUM*PE_ARRAY-1:0] r_act_vec, r_pend_vec;
  logic [4:0]                    r_act_shift, r_pend_shift;
  logic                          r_act_relu, r_pend_relu;
  logic                          r_act_full, r_pend_full;
  logic [IW-1:0]                 r_idx;
  logic                          r_overflow;

  logic w_xfer, w_last_xfer, w_drop;

  assign w_xfer      = r_act_full & i_Rdy;
  assign w_last_xfer = w_xfer & (r_idx == LAST_IDX);
  // Finishing the last lane this edge frees a slot, so a simultaneous capture still fits.
  assign w_drop      = i_Done & r_act_full & r_pend_full & ~w_last_xfer;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_act_vec    <= '0;
      r_act_shift  <= '0;
      r_act_relu   <= 1'b0;
      r_act_full   <= 1'b0;
      r_pend_vec   <= '0;
      r_pend_shift <= '0;
      r_pend_relu  <= 1'b0;
      r_pend_full  <= 1'b0;
      r_idx        <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_last_xfer) begin
        r_idx <= '0;
        if (r_pend_full) begin
          // Promote pending; a simultaneous capture refills pending.
          r_act_vec   <= r_pend_vec;
          r_act_shift <= r_pend_shift;
          r_act_relu  <= r_pend_relu;
          if (i_Done) begin
            r_pend_vec   <= i_Psum;
            r_pend_shift <= i_Shift;
            r_pend_relu  <= i_Relu;
          end else begin
            r_pend_full <= 1'b0;
          end
        end else if (i_Done) begin
          // Back-to-back capture goes straight into active with no bubble.
          r_act_vec   <= i_Psum;
          r_act_shift <= i_Shift;
          r_act_relu  <= i_Relu;
        end else begin
          r_act_full <= 1'b0;
        end
      end else if (!r_act_full) begin
        if (i_Done) begin
          r_act_vec   <= i_Psum;
          r_act_shift <= i_Shift;
          r_act_relu  <= i_Relu;
          r_act_full  <= 1'b1;
          r_idx       <= '0;
        end
      end else begin
        if (w_xfer) r_idx <= r_idx + 1'b1;
        if (i_Done && !r_pend_full) begin
          r_pend_vec   <= i_Psum;
          r_pend_shift <= i_Shift;
          r_pend_relu  <= i_Relu;
          r_pend_full  <= 1'b1;
        end
      end

      if (w_drop)         r_overflow <= 1'b1;
      else if (i_Clr_Err) r_overflow <= 1'b0;
    end
  end

  // Requantize the lane selected by r_idx; purely a function of registers.
  logic [BITS_PSUM-1:0]        w_lanes [PE_ARRAY];
  logic signed [BITS_PSUM-1:0] w_lane, w_shr, w_rl;
  logic [BITS_OUT-1:0]         w_q;

  for (genvar g = 0; g < PE_ARRAY; g++) begin : g_lane
    assign w_lanes[g] = r_act_vec[g*BITS_PSUM +: BITS_PSUM];
  end

  assign w_lane = $signed(w_lanes[r_idx]);
  // Shift amounts at or beyond the lane width fill with the sign bit (0 or -1).
  assign w_shr  = w_lane >>> r_act_shift;
  assign w_rl   = (r_act_relu && w_shr[BITS_PSUM-1]) ? '0 : w_shr;

  always_comb begin
    w_q = w_rl[BITS_OUT-1:0];
    if (w_rl > SAT_MAX)      w_q = SAT_MAX[BITS_OUT-1:0];
    else if (w_rl < SAT_MIN) w_q = SAT_MIN[BITS_OUT-1:0];
  end

  assign o_Vld      = r_act_full;
  assign o_Data     = w_q;
  assign o_Idx      = r_idx;
  assign o_Last     = r_act_full & (r_idx == LAST_IDX);
  assign o_Stall    = r_pend_full;
  assign o_Overflow = r_overflow;

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed scenarios plus a randomized phase, all checked
// against a queue of expected output beats with capacity-two capture semantics.
module tb_psum_drain;

  localparam int PE = 16;
  localparam int BP = 20;
  localparam int BO = 8;
  localparam int IW = $clog2(PE);

  logic              CLK = 1'b0;
  logic              RST;
  logic              i_Done;
  logic [BP*PE-1:0]  i_Psum;
  logic [4:0]        i_Shift;
  logic              i_Relu;
  logic              i_Clr_Err;
  logic              i_Rdy;
  logic              o_Vld;
  logic [BO-1:0]     o_Data;
  logic [IW-1:0]     o_Idx;
  logic              o_Last;
  logic              o_Stall;
  logic              o_Overflow;

  psum_drain #(.PE_ARRAY(PE), .BITS_PSUM(BP), .BITS_OUT(BO)) dut (
    .CLK(CLK), .RST(RST), .i_Done(i_Done), .i_Psum(i_Psum), .i_Shift(i_Shift),
    .i_Relu(i_Relu), .i_Clr_Err(i_Clr_Err), .i_Rdy(i_Rdy), .o_Vld(o_Vld),
    .o_Data(o_Data), .o_Idx(o_Idx), .o_Last(o_Last), .o_Stall(o_Stall),
    .o_Overflow(o_Overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BO-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  beat_t q[$];      // every beat still owed downstream, in order
  bit    m_ovf;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Requantization from the arithmetic definition: floor division, clamp, ReLU.
  function automatic logic [BO-1:0] ref_q(input logic [BP-1:0] raw, input int sh, input bit relu);
    longint x, d, s;
    x = longint'($signed(raw));
    d = longint'(1) << sh;
    if (x >= 0) s = x / d;
    else        s = -((-x + d - 1) / d);
    if (relu && s < 0) s = 0;
    if (s > 2 ** (BO - 1) - 1) s = 2 ** (BO - 1) - 1;
    if (s < -(2 ** (BO - 1)))  s = -(2 ** (BO - 1));
    return s[BO-1:0];
  endfunction

  task automatic push_vec(input logic [BP*PE-1:0] vec, input int sh, input bit relu);
    for (int i = 0; i < PE; i++)
      q.push_back('{data: ref_q(vec[i*BP +: BP], sh, relu), idx: i, last: (i == PE - 1)});
  endtask

  function automatic int vecs_held();
    return (q.size() + PE - 1) / PE;
  endfunction

  // One clock: check outputs, drive inputs, advance the model, cross the edge.
  task automatic step(input bit done, input logic [BP*PE-1:0] vec, input int sh,
                      input bit relu, input bit rdy, input bit clr);
    bit drop;
    chk("vld", o_Vld, q.size() > 0);
    if (q.size() > 0) begin
      chk("data", o_Data, q[0].data);
      chk("idx", o_Idx, q[0].idx);
      chk("last", o_Last, q[0].last);
    end
    chk("stall", o_Stall, vecs_held() == 2);
    chk("ovf", o_Overflow, m_ovf);
    i_Done = done; i_Psum = vec; i_Shift = sh[4:0]; i_Relu = relu;
    i_Rdy = rdy;   i_Clr_Err = clr;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    drop = 1'b0;
    if (done) begin
      if (vecs_held() < 2) push_vec(vec, sh, relu);
      else                 drop = 1'b1;
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, '0, 0, 1'b0, rdy, 1'b0);
  endtask

  function automatic logic [BP*PE-1:0] rand_vec();
    logic [BP*PE-1:0] v;
    for (int i = 0; i < PE; i++) begin
      if ($urandom_range(0, 1) == 0) v[i*BP +: BP] = BP'(int'($urandom_range(0, 600)) - 300);
      else                           v[i*BP +: BP] = BP'($urandom);
    end
    return v;
  endfunction

  function automatic logic [BP*PE-1:0] ramp_vec();
    logic [BP*PE-1:0] v;
    for (int i = 0; i < PE; i++) v[i*BP +: BP] = BP'(i - 8);
    return v;
  endfunction

  function automatic logic [BP*PE-1:0] sat_vec(input int a, input int b, input int c);
    logic [BP*PE-1:0] v;
    v = rand_vec();
    v[0*BP +: BP] = BP'(a);
    v[1*BP +: BP] = BP'(b);
    v[2*BP +: BP] = BP'(c);
    return v;
  endfunction

  // Hold the first lane, then step through lanes 0..2 with fixed expectations.
  task automatic sat_case(input string tag, input logic [BP*PE-1:0] v, input int sh, input bit relu,
                          input logic [BO-1:0] e0, input logic [BO-1:0] e1, input logic [BO-1:0] e2);
    step(1'b1, v, sh, relu, 1'b0, 1'b0);
    chk({tag, "_l0"}, o_Data, e0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
    chk({tag, "_l1"}, o_Data, e1);
    step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
    chk({tag, "_l2"}, o_Data, e2);
    idle(PE, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BP*PE-1:0] va, vb, vc;
    RST = 1'b0; i_Done = 1'b0; i_Psum = '0; i_Shift = '0; i_Relu = 1'b0;
    i_Clr_Err = 1'b0; i_Rdy = 1'b0; m_ovf = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_vld", o_Vld, 0);   chk("rst_data", o_Data, 0); chk("rst_idx", o_Idx, 0);
    chk("rst_last", o_Last, 0); chk("rst_stall", o_Stall, 0); chk("rst_ovf", o_Overflow, 0);
    RST = 1'b1;
    idle(2, 1'b1);

    // Single ramp vector at full rate.
    step(1'b1, ramp_vec(), 0, 1'b0, 1'b1, 1'b0);
    idle(PE + 4, 1'b1);

    // Shift, ReLU and saturation corners.
    sat_case("sat4",   sat_vec(5000, -5000, -3), 4, 1'b0, 8'h7F, 8'h80, 8'hFF);
    sat_case("sat4r",  sat_vec(5000, -5000, -3), 4, 1'b1, 8'h7F, 8'h00, 8'h00);
    sat_case("sh1",    sat_vec(-3, 5000, -5000), 1, 1'b0, 8'hFE, 8'h7F, 8'h80);
    sat_case("sh1r",   sat_vec(-3, 5000, -5000), 1, 1'b1, 8'h00, 8'h7F, 8'h00);
    sat_case("sh31",   sat_vec(-1, 5000, -5000), 31, 1'b0, 8'hFF, 8'h00, 8'hFF);

    // Backpressure pattern 1,0,0,1.
    step(1'b1, ramp_vec(), 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4 * PE + 4; k++) step(1'b0, '0, 0, 1'b0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
    idle(4, 1'b1);

    // Double buffer: second capture while lane 3 is presented.
    va = rand_vec(); vb = rand_vec();
    for (int s = 0; s < 2 * PE + 6; s++)
      step(s == 0 || s == 4, (s == 0) ? va : vb, s, 1'b0, 1'b1, 1'b0);

    // Third capture with both slots full: dropped, flag sticky until cleared.
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    for (int s = 0; s < 12; s++)
      step(s == 0 || s == 4 || s == 8, (s == 0) ? va : (s == 4) ? vb : vc, 2, 1'b1, 1'b1, 1'b0);
    chk("ovf_set", o_Overflow, 1);
    step(1'b0, '0, 0, 1'b0, 1'b1, 1'b1);
    chk("ovf_clr", o_Overflow, 0);
    idle(2 * PE + 4, 1'b1);

    // Third capture exactly on the last-lane handshake: nothing dropped.
    va = rand_vec(); vb = rand_vec(); vc = rand_vec();
    for (int s = 0; s <= PE; s++)
      step(s == 0 || s == 4 || s == PE, (s == 0) ? va : (s == 4) ? vb : vc, 3, 1'b0, 1'b1, 1'b0);
    chk("simul_no_drop", o_Overflow, 0);
    idle(2 * PE + 4, 1'b1);

    // Randomized traffic.
    for (int s = 0; s < 600; s++)
      step($urandom_range(0, 11) == 0, rand_vec(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8)),
           $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    idle(3 * PE, 1'b1);

    // Async reset at lane 7 with pending full.
    step(1'b1, rand_vec(), 1, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, rand_vec(), 1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !(q.size() > PE && q[0].idx == 7); k++) idle(1, 1'b1);
    chk("pre_rst_idx", o_Idx, 7);
    chk("pre_rst_stall", o_Stall, 1);
    i_Rdy = 1'b1; i_Done = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("arst_vld", o_Vld, 0);   chk("arst_data", o_Data, 0); chk("arst_idx", o_Idx, 0);
    chk("arst_last", o_Last, 0); chk("arst_stall", o_Stall, 0); chk("arst_ovf", o_Overflow, 0);
    @(posedge CLK); @(negedge CLK);
    chk("arst_done_ignored", o_Vld, 0);
    i_Done = 1'b0;
    RST = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    idle(PE + 4, 1'b1);
    step(1'b1, ramp_vec(), 0, 1'b0, 1'b1, 1'b0);
    idle(PE + 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
